pe_arb: RTL and testbench

Parametrised, registered successor to the team's 4-to-2 priority encoder: N request lines, sticky capture of pending requests, selectable fixed-priority or round-robin selection, and a valid/ready output that presents one encoded winner at a time. It sits between request sources (interrupt or event lines) and a single consumer that services one request per handshake. No request pulse is lost while the consumer stalls.

---
 rtl/pe_arb_if.sv | 31 +++
 rtl/pe_arb.sv | 77 +++++++
 tb/tb_pe_arb.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_arb_if.sv
// Request/grant bundle between request sources, the arbiter and its consumer.
interface pe_arb_if #(
  parameter int N = 4
) ();
  localparam int W = $clog2(N);

  logic [N-1:0] req;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_onehot;
  logic [N-1:0] pending;

  modport master (
    output req,
    output out_ready,
    input  out_valid,
    input  out_idx,
    input  out_onehot,
    input  pending
  );

  modport slave (
    input  req,
    input  out_ready,
    output out_valid,
    output out_idx,
    output out_onehot,
    output pending
  );
endinterface

// File: rtl/pe_arb.sv
// Registered N-line priority arbiter: sticky request capture, fixed or
// round-robin selection, one encoded winner per valid/ready handshake.
module pe_arb #(
  parameter int N    = 4,
  parameter int MODE = 0
) (
  input  logic     clk,
  input  logic     rst,
  pe_arb_if.slave  bus
);
  localparam int W = $clog2(N);

  logic         r_valid;
  logic [W-1:0] r_idx;
  logic [N-1:0] r_onehot;
  logic [N-1:0] r_pend;
  logic [W-1:0] r_ptr;

  logic [N-1:0] w_cand;
  logic         w_load;
  logic [W-1:0] w_win;
  logic [N-1:0] w_oh;

  assign w_cand = r_pend | bus.req;
  assign w_load = !r_valid || bus.out_ready;

  // Round-robin walks downward from ptr-1, so ptr itself is tried last.
  always_comb begin
    logic hit;
    w_win = '0;
    hit   = 1'b0;
    if (MODE == 0) begin
      for (int i = 0; i < N; i++)
        if (w_cand[i]) w_win = W'(i);
    end else begin
      for (int k = 1; k <= N; k++)
        if (!hit && w_cand[(int'(r_ptr) + N - k) % N]) begin
          w_win = W'((int'(r_ptr) + N - k) % N);
          hit   = 1'b1;
        end
    end
  end

  always_comb begin
    w_oh        = '0;
    w_oh[w_win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_onehot <= '0;
      r_pend   <= '0;
      r_ptr    <= '0;
    end else if (w_load) begin
      if (|w_cand) begin
        r_valid  <= 1'b1;
        r_idx    <= w_win;
        r_onehot <= w_oh;
        r_pend   <= w_cand & ~w_oh;
        if (MODE != 0) r_ptr <= w_win;
      end else begin
        r_valid  <= 1'b0;
        r_onehot <= '0;
        r_pend   <= '0;
      end
    end else begin
      r_pend <= w_cand;
    end
  end

  assign bus.out_valid  = r_valid;
  assign bus.out_idx    = r_idx;
  assign bus.out_onehot = r_onehot;
  assign bus.pending    = r_pend;
endmodule

// File: tb/tb_pe_arb.sv
// Bench for pe_arb: directed vector table, corner sequences and random
// traffic against a rank-based reference model, both MODE values at N=4.
module tb_pe_arb;
  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         rdy;
  int           total = 0;
  int           bad   = 0;

  always #5 clk = ~clk;

  pe_arb_if #(.N(N)) b0 ();
  pe_arb_if #(.N(N)) b1 ();

  assign b0.req       = req;
  assign b0.out_ready = rdy;
  assign b1.req       = req;
  assign b1.out_ready = rdy;

  pe_arb #(.N(N), .MODE(0)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (b0.slave)
  );

  pe_arb #(.N(N), .MODE(1)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  // Reference state per mode (index 0 = fixed, 1 = round-robin)
  logic         mv  [2];
  int           mi  [2];
  logic [N-1:0] mp  [2];
  int           mptr[2];

  typedef struct {
    logic [N-1:0] req;
    logic         rdy;
    logic         ev;
    int           ei;
    logic [N-1:0] ep;
  } vec_t;

  vec_t vt[14];

  function automatic int pick(int mode, logic [N-1:0] c, int ptr);
    int best;
    int brank;
    int v;
    best  = 0;
    brank = -1;
    if (mode == 0) begin
      v = int'(c);
      while (v > 1) begin
        v = v >> 1;
        best++;
      end
    end else begin
      for (int i = 0; i < N; i++)
        if (c[i] && ((i - ptr + N) % N) > brank) begin
          brank = (i - ptr + N) % N;
          best  = i;
        end
    end
    return best;
  endfunction

  task automatic tick();
    logic         nv[2];
    int           ni[2];
    logic [N-1:0] np[2];
    int           nptr[2];
    logic [N-1:0] cand;
    int           w;
    for (int m = 0; m < 2; m++) begin
      nv[m] = mv[m]; ni[m] = mi[m]; np[m] = mp[m]; nptr[m] = mptr[m];
      cand = mp[m] | req;
      if (rst) begin
        nv[m] = 1'b0; ni[m] = 0; np[m] = '0; nptr[m] = 0;
      end else if (!mv[m] || rdy) begin
        if (cand != '0) begin
          w = pick(m, cand, mptr[m]);
          nv[m] = 1'b1;
          ni[m] = w;
          np[m] = cand & ~(N'(1) << w);
          if (m == 1) nptr[m] = w;
        end else begin
          nv[m] = 1'b0;
          np[m] = '0;
        end
      end else begin
        np[m] = cand;
      end
    end
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      mv[m] = nv[m]; mi[m] = ni[m]; mp[m] = np[m]; mptr[m] = nptr[m];
    end
  endtask

  task automatic chk(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_model();
    int eoh0;
    int eoh1;
    eoh0 = mv[0] ? (1 << mi[0]) : 0;
    eoh1 = mv[1] ? (1 << mi[1]) : 0;
    chk("m0_valid", int'(b0.out_valid), int'(mv[0]));
    chk("m0_idx", int'(b0.out_idx), mi[0]);
    chk("m0_onehot", int'(b0.out_onehot), eoh0);
    chk("m0_pend", int'(b0.pending), int'(mp[0]));
    chk("m1_valid", int'(b1.out_valid), int'(mv[1]));
    chk("m1_idx", int'(b1.out_idx), mi[1]);
    chk("m1_onehot", int'(b1.out_onehot), eoh1);
    chk("m1_pend", int'(b1.pending), int'(mp[1]));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    rdy = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int           grants[$];
    logic [N-1:0] a;
    int           ey;
    logic         distinct;

    for (int m = 0; m < 2; m++) begin
      mv[m] = 1'b0; mi[m] = 0; mp[m] = '0; mptr[m] = 0;
    end
    rst = 1'b1;
    req = '0;
    rdy = 1'b0;

    vt[0]  = '{4'b0110, 1'b1, 1'b1, 2, 4'b0010};
    vt[1]  = '{4'b0000, 1'b1, 1'b1, 1, 4'b0000};
    vt[2]  = '{4'b0000, 1'b1, 1'b0, 1, 4'b0000};
    vt[3]  = '{4'b0001, 1'b0, 1'b1, 0, 4'b0000};
    vt[4]  = '{4'b0000, 1'b0, 1'b1, 0, 4'b0000};
    vt[5]  = '{4'b0000, 1'b0, 1'b1, 0, 4'b0000};
    vt[6]  = '{4'b1000, 1'b0, 1'b1, 0, 4'b1000};
    vt[7]  = '{4'b0000, 1'b0, 1'b1, 0, 4'b1000};
    vt[8]  = '{4'b0000, 1'b1, 1'b1, 3, 4'b0000};
    vt[9]  = '{4'b0000, 1'b1, 1'b0, 3, 4'b0000};
    vt[10] = '{4'b0010, 1'b0, 1'b1, 1, 4'b0000};
    vt[11] = '{4'b0010, 1'b0, 1'b1, 1, 4'b0010};
    vt[12] = '{4'b0000, 1'b1, 1'b1, 1, 4'b0000};
    vt[13] = '{4'b0000, 1'b1, 1'b0, 1, 4'b0000};

    do_reset();
    chk("rst_valid", int'(b0.out_valid), 0);
    chk("rst_idx", int'(b0.out_idx), 0);
    chk("rst_onehot", int'(b0.out_onehot), 0);
    chk("rst_pend", int'(b0.pending), 0);
    chk("rst_ptr", int'(u1.r_ptr), 0);

    // Directed table: fixed priority, stall hold, presented-index re-request
    for (int i = 0; i < 14; i++) begin
      req = vt[i].req;
      rdy = vt[i].rdy;
      tick();
      req = '0;
      chk($sformatf("vec%0d_valid", i), int'(b0.out_valid), int'(vt[i].ev));
      chk($sformatf("vec%0d_idx", i), int'(b0.out_idx), vt[i].ei);
      chk($sformatf("vec%0d_pend", i), int'(b0.pending), int'(vt[i].ep));
      chk($sformatf("vec%0d_onehot", i), int'(b0.out_onehot),
          vt[i].ev ? (1 << vt[i].ei) : 0);
      chk_model();
    end

    // Old 4-to-2 encoder equivalence
    for (int v = 0; v < 16; v++) begin
      do_reset();
      a   = N'(v);
      req = a;
      rdy = 1'b1;
      tick();
      req = '0;
      ey = {30'd0, a[3] | a[2], a[3] | (~a[2] & a[1])};
      chk($sformatf("enc%0d_v", v), int'(b0.out_valid), int'(|a));
      chk($sformatf("enc%0d_y", v), int'(b0.out_idx), ey);
    end

    // Round-robin fairness with all lines held
    do_reset();
    req = 4'b1111;
    rdy = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      grants.push_back(int'(b1.out_idx));
      chk($sformatf("rr%0d_idx", k), int'(b1.out_idx), 3 - (k % 4));
      chk($sformatf("rr%0d_valid", k), int'(b1.out_valid), 1);
      if (k >= 3) begin
        distinct = 1'b1;
        for (int p = k - 3; p <= k; p++)
          for (int q = p + 1; q <= k; q++)
            if (grants[p] == grants[q]) distinct = 1'b0;
        chk($sformatf("rr_win%0d", k), int'(distinct), 1);
      end
    end
    req = '0;

    // Reset mid-operation in round-robin mode
    do_reset();
    req = 4'b1000;
    tick();
    req = 4'b0111;
    tick();
    req = '0;
    chk("mid_valid", int'(b1.out_valid), 1);
    chk("mid_pend", int'(b1.pending), 4'b0111);
    rst = 1'b1;
    req = 4'b1111;
    tick();
    rst = 1'b0;
    req = '0;
    chk("mr_valid", int'(b1.out_valid), 0);
    chk("mr_idx", int'(b1.out_idx), 0);
    chk("mr_onehot", int'(b1.out_onehot), 0);
    chk("mr_pend", int'(b1.pending), 0);
    chk("mr_ptr", int'(u1.r_ptr), 0);
    req = 4'b0101;
    rdy = 1'b1;
    tick();
    req = '0;
    chk("mr_first", int'(b1.out_idx), 2);
    tick();
    chk("mr_second", int'(b1.out_idx), 0);

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      req = N'($urandom_range(0, 15) & $urandom_range(0, 15));
      rdy = ($urandom_range(0, 2) != 0);
      tick();
      chk_model();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
